// File: rtl/layernorm_lane_scheduler.sv
// rtl/layernorm_lane_scheduler.sv - round-robin LayerNorm lane scheduler with in-order reassembly
// layernorm_nnlut here is a latency-parameterised affine core model (y = x*w + b per feature).

module layernorm_nnlut #(
  parameter int INPUT_WIDTH  = 8,
  parameter int INPUT_NUM    = 768,
  parameter int OUTPUT_WIDTH = 8,
  parameter int LATENCY      = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INPUT_WIDTH*INPUT_NUM-1:0]  data,
  input  logic [INPUT_WIDTH*INPUT_NUM-1:0]  w,
  input  logic [INPUT_WIDTH*INPUT_NUM-1:0]  b,
  input  logic                              data_valid_n,
  input  logic                              w_valid_n,
  input  logic                              b_valid_n,
  output logic [OUTPUT_WIDTH*INPUT_NUM-1:0] result,
  output logic                              result_valid_n
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int AW = 2 * INPUT_WIDTH;

  logic [CW-1:0]                     remain;
  logic [AW-1:0]                     acc;
  logic [OUTPUT_WIDTH*INPUT_NUM-1:0] affine;
  logic                              start;

  assign start = !data_valid_n && !w_valid_n && !b_valid_n;

  always_comb begin
    acc    = '0;
    affine = '0;
    for (int j = 0; j < INPUT_NUM; j++) begin
      acc = AW'(data[j*INPUT_WIDTH +: INPUT_WIDTH]) * AW'(w[j*INPUT_WIDTH +: INPUT_WIDTH])
          + AW'(b[j*INPUT_WIDTH +: INPUT_WIDTH]);
      affine[j*OUTPUT_WIDTH +: OUTPUT_WIDTH] = acc[OUTPUT_WIDTH-1:0];
    end
  end

  // One row in flight per core: the scheduler never restrobes a lane before its result is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      remain         <= '0;
      result         <= '0;
      result_valid_n <= 1'b1;
    end else begin
      result_valid_n <= 1'b1;
      if (start) begin
        result <= affine;
        if (LATENCY <= 1) result_valid_n <= 1'b0;
        else              remain         <= CW'(LATENCY - 1);
      end else if (remain != '0) begin
        remain <= remain - CW'(1);
        if (remain == CW'(1)) result_valid_n <= 1'b0;
      end
    end
  end
endmodule

module layernorm_lane_scheduler #(
  parameter int                    INPUT_WIDTH  = 8,
  parameter int                    INPUT_NUM    = 768,
  parameter int                    OUTPUT_WIDTH = 8,
  parameter int                    SENTENCE_NUM = 128,
  parameter int                    LANE_NUM     = 4,
  parameter logic [8*LANE_NUM-1:0] LANE_LATENCY = {LANE_NUM{8'd5}}
) (
  input  logic                               clk_p,
  input  logic                               rst_p,
  input  logic [INPUT_WIDTH*INPUT_NUM-1:0]   w,
  input  logic [INPUT_WIDTH*INPUT_NUM-1:0]   b,
  input  logic                               wb_load,
  input  logic [INPUT_WIDTH*INPUT_NUM-1:0]   row_in,
  input  logic                               row_in_valid,
  output logic                               row_in_ready,
  output logic [OUTPUT_WIDTH*INPUT_NUM-1:0]  row_out,
  output logic                               row_out_valid,
  input  logic                               row_out_ready,
  output logic [$clog2(SENTENCE_NUM)-1:0]    row_out_idx,
  output logic                               busy,
  output logic                               frame_done
);
  localparam int RW    = INPUT_WIDTH * INPUT_NUM;
  localparam int OW    = OUTPUT_WIDTH * INPUT_NUM;
  localparam int IDX_W = $clog2(SENTENCE_NUM);
  localparam int CNT_W = $clog2(SENTENCE_NUM + 1);
  localparam int PTR_W = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic                wb_ok;
  logic [RW-1:0]       w_reg, b_reg;
  logic [RW-1:0]       lane_in     [LANE_NUM];
  logic [OW-1:0]       lane_buf    [LANE_NUM];
  logic [OW-1:0]       lane_result [LANE_NUM];
  logic [LANE_NUM-1:0] lane_busy, out_full, strobe_n, result_valid_n;
  logic [CNT_W-1:0]    in_cnt;
  logic [IDX_W-1:0]    out_cnt;
  logic [PTR_W-1:0]    disp_ptr, out_ptr;
  logic                accept_in, accept_out;

  function automatic logic [PTR_W-1:0] step(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LANE_NUM - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign row_in_ready  = wb_ok && (in_cnt < CNT_W'(SENTENCE_NUM)) && !lane_busy[disp_ptr];
  assign row_out_valid = out_full[out_ptr];
  assign row_out       = lane_buf[out_ptr];
  assign row_out_idx   = out_cnt;
  assign busy          = (state == RUN);
  assign accept_in     = row_in_valid && row_in_ready;
  assign accept_out    = row_out_valid && row_out_ready;

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state      <= IDLE;
      wb_ok      <= 1'b0;
      w_reg      <= '0;
      b_reg      <= '0;
      lane_busy  <= '0;
      out_full   <= '0;
      strobe_n   <= '1;
      in_cnt     <= '0;
      out_cnt    <= '0;
      disp_ptr   <= '0;
      out_ptr    <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < LANE_NUM; i++) begin
        lane_in[i]  <= '0;
        lane_buf[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      strobe_n   <= '1;
      if (state == IDLE && wb_load) begin
        w_reg <= w;
        b_reg <= b;
        wb_ok <= 1'b1;
      end
      // Results from idle lanes (e.g. work in flight across a reset) are dropped.
      for (int i = 0; i < LANE_NUM; i++) begin
        if (!result_valid_n[i] && lane_busy[i]) begin
          lane_buf[i] <= lane_result[i];
          out_full[i] <= 1'b1;
        end
      end
      if (accept_out) begin
        out_full[out_ptr]  <= 1'b0;
        lane_busy[out_ptr] <= 1'b0;
        if (out_cnt == IDX_W'(SENTENCE_NUM - 1)) begin
          in_cnt     <= '0;
          out_cnt    <= '0;
          disp_ptr   <= '0;
          out_ptr    <= '0;
          state      <= IDLE;
          frame_done <= 1'b1;
        end else begin
          out_cnt <= out_cnt + IDX_W'(1);
          out_ptr <= step(out_ptr);
        end
      end
      if (accept_in) begin
        lane_in[disp_ptr]   <= row_in;
        lane_busy[disp_ptr] <= 1'b1;
        strobe_n[disp_ptr]  <= 1'b0;
        in_cnt              <= in_cnt + CNT_W'(1);
        disp_ptr            <= step(disp_ptr);
        state               <= RUN;
      end
    end
  end

  for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
    layernorm_nnlut #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .INPUT_NUM   (INPUT_NUM),
      .OUTPUT_WIDTH(OUTPUT_WIDTH),
      .LATENCY     (int'(LANE_LATENCY[8*i +: 8]))
    ) u_core (
      .clk           (clk_p),
      .rst           (rst_p),
      .data          (lane_in[i]),
      .w             (w_reg),
      .b             (b_reg),
      .data_valid_n  (strobe_n[i]),
      .w_valid_n     (strobe_n[i]),
      .b_valid_n     (strobe_n[i]),
      .result        (lane_result[i]),
      .result_valid_n(result_valid_n[i])
    );
  end
endmodule

// File: doc/layernorm_lane_scheduler.md
# layernorm_lane_scheduler

Time-multiplexed LayerNorm engine. It streams SENTENCE_NUM rows of INPUT_NUM features through LANE_NUM instances of `layernorm_nnlut`, instead of instantiating one core per sentence. The block sits between the attention/FFN residual output and the next op_trans stage. It accepts rows over a valid/ready stream, dispatches them round-robin to free lanes, and returns normalised rows strictly in input order over a valid/ready stream. The per-feature affine parameters w/b are loaded once per frame and shared by all lanes.

## Interface
- INPUT_WIDTH, 8, bits per input feature, w and b element
- INPUT_NUM, 768, features per row
- OUTPUT_WIDTH, 8, bits per output feature
- SENTENCE_NUM, 128, rows per frame
- LANE_NUM, 4, parallel `layernorm_nnlut` instances (1..SENTENCE_NUM; need not be a power of two)

- clk_p  in  1  single clock; all logic rising-edge
- rst_p  in  1  synchronous, active-high reset
- w  in  INPUT_WIDTH*INPUT_NUM  gamma vector, sampled on wb_load
- b  in  INPUT_WIDTH*INPUT_NUM  beta vector, sampled on wb_load
- wb_load  in  1  one-cycle strobe; latch w/b
- row_in  in  INPUT_WIDTH*INPUT_NUM  input row
- row_in_valid  in  1  row_in valid
- row_in_ready  out  1  block can accept row_in this cycle
- row_out  out  OUTPUT_WIDTH*INPUT_NUM  normalised row
- row_out_valid  out  1  row_out valid
- row_out_ready  in  1  downstream accepts row_out
- row_out_idx  out  $clog2(SENTENCE_NUM)  row index of row_out within the frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last row of a frame is accepted downstream

## Operation
- States:
  - IDLE: wb_load sets the wb_ok flag and latches w/b.
  - RUN: entered on the first row accepted while wb_ok is set.
  - back to IDLE: on the SENTENCE_NUM-th output handshake, with frame_done pulsed.
  - wb_ok persists across frames. wb_load outside IDLE is ignored.
- row_in_ready = wb_ok & (in_cnt < SENTENCE_NUM) & lane_free[disp_ptr]. This is combinational from registers; it does not depend on row_in_valid.
- Dispatch: on row_in_valid & row_in_ready:
  - latch row_in into lane[disp_ptr]'s input register;
  - set lane busy;
  - in_cnt++;
  - disp_ptr = (disp_ptr==LANE_NUM-1) ? 0 : disp_ptr+1.
  - Next cycle, drive data_valid_n, w_valid_n and b_valid_n low for exactly one cycle to that lane. w/b come from the shared latched registers.
- Completion: when a lane's result_valid_n is low for a cycle, latch its result into that lane's output buffer and set out_full. A pulse from a lane that is not busy is ignored.
- Ordering: out_ptr steps round-robin identically to disp_ptr.
  - row_out_valid = out_full[out_ptr]; row_out = buffer[out_ptr]; row_out_idx = out_cnt.
  - Lanes may complete in any order. Output order always equals input order.
- Release: on row_out_valid & row_out_ready, clear out_full and busy of lane[out_ptr], out_cnt++, advance out_ptr. A lane is free only after its result has been consumed, so buffers cannot overflow.
- Simultaneous dispatch to, and release of, the same lane in one cycle: release takes effect first, so the lane is free at the next edge, not the same cycle.
- End of frame: after SENTENCE_NUM outputs:
  - in_cnt, out_cnt, disp_ptr and out_ptr clear to 0;
  - return to IDLE;
  - frame_done=1 for one cycle.
- rst_p (any time, including mid-frame):
  - state IDLE; wb_ok=0; all lane busy/out_full cleared; counters and pointers 0;
  - lane valid_n strobes driven high;
  - results arriving from lanes afterwards are ignored.
- Reset values: row_in_ready=0, row_out_valid=0, row_out=0, row_out_idx=0, busy=0, frame_done=0.

## Timing
- Input handshake at edge t: lane strobe low during cycle t+1.
- Lane result_valid_n low in cycle r: row_out_valid=1 in cycle r+1, provided that lane is the out_ptr lane.
- Latency = core latency + 2 cycles.
- Throughput with free lanes: one row per cycle. Steady state: LANE_NUM rows per core latency.
- row_out, row_out_idx and row_out_valid hold stable while row_out_valid & !row_out_ready.
- busy = (state==RUN). busy is 1 in the cycle after the first input handshake and 0 in the cycle frame_done is 1.

## Test plan
- Reset: hold rst_p for 2 cycles, then drive row_in_valid=1 without wb_load -> row_in_ready stays 0, all outputs 0.
- Single frame, SENTENCE_NUM=8, LANE_NUM=4, lane stub latency 5, row k = constant k, w=1, b=0 -> 8 outputs with row_out_idx 0..7 in order; first row_out_valid 7 cycles after the first handshake; one frame_done pulse.
- Out-of-order completion, lane latencies {9,3,6,2} -> outputs still in idx order 0..7; no row_out changes while row_out_ready=0.
- Backpressure: row_out_ready=0 for 20 cycles -> exactly LANE_NUM rows accepted, then row_in_ready=0; on release the remaining rows flow with no loss or duplication.
- wb_load during RUN with new w=2 -> frame continues using w=1; the next frame after a fresh wb_load in IDLE uses w=2.
- rst_p asserted mid-frame after 3 outputs -> next cycle all outputs 0, wb_ok cleared; late lane result pulses produce no row_out_valid.
